// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared pipeline types for the MEM-stage access controller
// Holds the access FSM state encoding and the pass-through control field widths.
package mem_access_ctrl_pkg;

    localparam int WB_W       = 2;
    localparam int RD_W       = 5;
    localparam int ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_access_ctrl_store_buf.sv
// rtl/mem_access_ctrl_store_buf.sv - one-entry posted store buffer (built with MEM_STORE_BUFFER_EN)
// Holds a single word-aligned store until the memory port acknowledges its drain.
module mem_store_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        // The entry is released only once the drain write has been acknowledged.
        if (pop_i) begin
            valid_d = 1'b0;
        end else if (push_i && !valid_q) begin
            valid_d = 1'b1;
            addr_d  = push_addr_i;
            data_d  = push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage controller bridging loads/stores to a req/ack memory port
// Optional posted store buffer selected by MEM_STORE_BUFFER_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    mem_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              stall;
    logic [ADDR_W-1:0] addr_aligned;

    assign addr_aligned = {addr_i[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

`ifdef MEM_STORE_BUFFER_EN
    logic              buf_push;
    logic              buf_pop;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    mem_store_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (buf_push),
        .push_addr_i (addr_aligned),
        .push_data_i (wdata_i),
        .pop_i       (buf_pop),
        .valid_o     (buf_valid),
        .addr_o      (buf_addr),
        .data_o      (buf_data)
    );
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_d      = data_q;
        stall       = 1'b0;
`ifdef MEM_STORE_BUFFER_EN
        buf_push    = 1'b0;
        buf_pop     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MEM_STORE_BUFFER_EN
                // A pending buffered store always drains first so loads see it.
                if (buf_valid) begin
                    stall       = MemRead_i | MemWrite_i;
                    state_d     = ST_WR_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = buf_addr;
                    mem_wdata_d = buf_data;
                end else if (MemRead_i) begin
                    stall       = 1'b1;
                    state_d     = ST_RD_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = addr_aligned;
                end else if (MemWrite_i) begin
                    buf_push    = 1'b1;
                end
`else
                // Read wins when both strobes are set.
                if (MemRead_i) begin
                    stall       = 1'b1;
                    state_d     = ST_RD_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = addr_aligned;
                end else if (MemWrite_i) begin
                    stall       = 1'b1;
                    state_d     = ST_WR_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_aligned;
                    mem_wdata_d = wdata_i;
                end
`endif
            end
            ST_RD_WAIT: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    data_d    = mem_rdata_i;
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_WR_WAIT: begin
`ifdef MEM_STORE_BUFFER_EN
                // Drains are posted: only a waiting memory op is held back.
                stall = MemRead_i | MemWrite_i;
                if (mem_ack_i) begin
                    buf_pop   = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
`else
                stall = 1'b1;
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                stall   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_q      <= data_d;
        end
    end

    // Strobes may be live during reset; keep stall quiet until release.
    assign stall_o     = stall & rst_i;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign data_o      = data_q;
    assign WB_o        = WB_i;
    assign rd_o        = rd_i;
    assign addr_o      = addr_i;

endmodule
